// File: rtl/axis_fir_pkg.sv
// Shared definitions for the AXI-Stream FIR filter and its run-time coefficient loader.
// Both blocks size their coefficient half-set with n_half().
package axis_fir_pkg;

    typedef enum logic [1:0] {
        ST_RECEIVE,
        ST_FLUSH,
        ST_DRAIN,
        ST_WRITE
    } loader_fsm_t;

    // Symmetric filters store only half of the taps; the address MSB selects the mirror.
    function automatic int n_half(input int addr_width);
        return 1 << (addr_width - 1);
    endfunction

endpackage

// File: rtl/fir_coeff_shadow_ram.sv
// Simple dual-port shadow buffer for one coefficient half-set, registered read.
// The read register returns zero whenever no read is requested.
module fir_coeff_shadow_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // NOTE: the storage array is deliberately not reset so it maps onto plain RAM;
    // only the small read register is reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end else begin
            rd_data_q <= '0;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axis_fir_coeff_loader.sv
// Receives a coefficient half-set over AXI-Stream, gates the filter's sample input until
// the in-flight calculation drains, then replays the set onto the filter coefficient port.
module axis_fir_coeff_loader
    import axis_fir_pkg::*;
#(
    parameter int N_BYTES          = 4,
    parameter int COEFF_ADDR_WIDTH = 6,
    localparam int DATA_WIDTH      = N_BYTES * 8
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [DATA_WIDTH-1:0]       S_AXIS_COEFF_TDATA,
    input  logic                        S_AXIS_COEFF_TVALID,
    output logic                        S_AXIS_COEFF_TREADY,
    input  logic                        S_AXIS_COEFF_TLAST,
    input  logic [DATA_WIDTH-1:0]       S_AXIS_TDATA,
    input  logic                        S_AXIS_TVALID,
    output logic                        S_AXIS_TREADY,
    output logic [DATA_WIDTH-1:0]       M_AXIS_TDATA,
    output logic                        M_AXIS_TVALID,
    input  logic                        M_AXIS_TREADY,
    input  logic                        FILT_OUT_TVALID,
    input  logic                        FILT_OUT_TREADY,
    output logic [COEFF_ADDR_WIDTH-1:0] COEFF_ADDR,
    output logic [DATA_WIDTH-1:0]       COEFF_DATA,
    output logic                        COEFF_VALID,
    output logic                        LOAD_DONE,
    output logic                        LOAD_ERROR,
    output logic                        BUSY
);

    localparam int IDX_W  = COEFF_ADDR_WIDTH - 1;
    localparam int N_HALF = n_half(COEFF_ADDR_WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_HALF - 1);

    loader_fsm_t      state_q, state_d;
    logic [IDX_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0] coeff_addr_q, coeff_addr_d;
    logic             coeff_valid_q, coeff_valid_d;
    logic             load_done_q, load_done_d;
    logic             load_error_q, load_error_d;
    logic             busy_q, busy_d;
    logic             gate_open_q, gate_open_d;
    logic             in_flight_q, in_flight_d;
    logic             coeff_hs, sample_hs, result_hs, shadow_we;

    // Sample path is a gated combinational pass-through.
    assign M_AXIS_TDATA  = S_AXIS_TDATA;
    assign M_AXIS_TVALID = S_AXIS_TVALID & gate_open_q;
    assign S_AXIS_TREADY = M_AXIS_TREADY & gate_open_q;

    assign S_AXIS_COEFF_TREADY = (state_q == ST_RECEIVE) || (state_q == ST_FLUSH);
    assign coeff_hs  = S_AXIS_COEFF_TVALID & S_AXIS_COEFF_TREADY;
    assign sample_hs = M_AXIS_TVALID & M_AXIS_TREADY;
    assign result_hs = FILT_OUT_TVALID & FILT_OUT_TREADY;

    // A new sample entering the filter outranks a result leaving it in the same cycle.
    assign in_flight_d = sample_hs ? 1'b1 : (result_hs ? 1'b0 : in_flight_q);

    // NOTE: every signal driven here gets a default first, so no path can infer a latch;
    // combinational logic uses blocking '=' while the state register below uses '<='.
    always_comb begin
        state_d       = state_q;
        rx_cnt_d      = rx_cnt_q;
        wr_idx_d      = wr_idx_q;
        coeff_valid_d = 1'b0;
        coeff_addr_d  = '0;
        load_done_d   = 1'b0;
        load_error_d  = 1'b0;
        shadow_we     = 1'b0;

        unique case (state_q)
            ST_RECEIVE: begin
                if (coeff_hs) begin
                    shadow_we = 1'b1;
                    if (rx_cnt_q == LAST_IDX) begin
                        rx_cnt_d = '0;
                        state_d  = S_AXIS_COEFF_TLAST ? ST_DRAIN : ST_FLUSH;
                    end else if (S_AXIS_COEFF_TLAST) begin
                        load_error_d = 1'b1;
                        rx_cnt_d     = '0;
                    end else begin
                        rx_cnt_d = rx_cnt_q + 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                if (coeff_hs && S_AXIS_COEFF_TLAST) begin
                    load_error_d = 1'b1;
                    rx_cnt_d     = '0;
                    state_d      = ST_RECEIVE;
                end
            end
            ST_DRAIN: begin
                if (!in_flight_q) begin
                    state_d       = ST_WRITE;
                    wr_idx_d      = '0;
                    coeff_valid_d = 1'b1;
                end
            end
            ST_WRITE: begin
                if (wr_idx_q == LAST_IDX) begin
                    state_d     = ST_RECEIVE;
                    load_done_d = 1'b1;
                end else begin
                    wr_idx_d      = wr_idx_q + 1'b1;
                    coeff_valid_d = 1'b1;
                    coeff_addr_d  = wr_idx_q + 1'b1;
                end
            end
            default: state_d = ST_RECEIVE;
        endcase
    end

    assign busy_d      = (state_d == ST_DRAIN) || (state_d == ST_WRITE);
    assign gate_open_d = (state_d == ST_RECEIVE) || (state_d == ST_FLUSH);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= ST_RECEIVE;
            rx_cnt_q      <= '0;
            wr_idx_q      <= '0;
            coeff_addr_q  <= '0;
            coeff_valid_q <= 1'b0;
            load_done_q   <= 1'b0;
            load_error_q  <= 1'b0;
            busy_q        <= 1'b0;
            gate_open_q   <= 1'b1;
            in_flight_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            rx_cnt_q      <= rx_cnt_d;
            wr_idx_q      <= wr_idx_d;
            coeff_addr_q  <= coeff_addr_d;
            coeff_valid_q <= coeff_valid_d;
            load_done_q   <= load_done_d;
            load_error_q  <= load_error_d;
            busy_q        <= busy_d;
            gate_open_q   <= gate_open_d;
            in_flight_q   <= in_flight_d;
        end
    end

    // Read address runs one cycle ahead so the RAM output lines up with COEFF_VALID.
    fir_coeff_shadow_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(IDX_W)
    ) u_shadow (
        .clk_i    (CLK),
        .rst_i    (RESET),
        .wr_en_i  (shadow_we),
        .wr_addr_i(rx_cnt_q),
        .wr_data_i(S_AXIS_COEFF_TDATA),
        .rd_en_i  (coeff_valid_d),
        .rd_addr_i(coeff_addr_d),
        .rd_data_o(COEFF_DATA)
    );

    assign COEFF_ADDR  = {1'b0, coeff_addr_q};
    assign COEFF_VALID = coeff_valid_q;
    assign LOAD_DONE   = load_done_q;
    assign LOAD_ERROR  = load_error_q;
    assign BUSY        = busy_q;

endmodule

// File: tb/tb_axis_fir_coeff_loader.sv
// Scoreboard bench for axis_fir_coeff_loader: a set-level reference model predicts
// coefficient writes, LOAD_DONE and LOAD_ERROR with their cycles; a monitor checks them.
module tb_axis_fir_coeff_loader;
    import axis_fir_pkg::*;

    localparam int DW     = 32;
    localparam int AW     = 6;
    localparam int N_HALF = n_half(AW);

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] coeff_tdata;
    logic          coeff_tvalid, coeff_tready, coeff_tlast;
    logic [DW-1:0] s_tdata, m_tdata;
    logic          s_tvalid, s_tready, m_tvalid, m_tready;
    logic          filt_tvalid, filt_tready;
    logic [AW-1:0] coeff_addr;
    logic [DW-1:0] coeff_data;
    logic          coeff_valid, load_done, load_error, busy;

    axis_fir_coeff_loader #(.N_BYTES(4), .COEFF_ADDR_WIDTH(AW)) dut (
        .CLK                (clk),
        .RESET              (rst),
        .S_AXIS_COEFF_TDATA (coeff_tdata),
        .S_AXIS_COEFF_TVALID(coeff_tvalid),
        .S_AXIS_COEFF_TREADY(coeff_tready),
        .S_AXIS_COEFF_TLAST (coeff_tlast),
        .S_AXIS_TDATA       (s_tdata),
        .S_AXIS_TVALID      (s_tvalid),
        .S_AXIS_TREADY      (s_tready),
        .M_AXIS_TDATA       (m_tdata),
        .M_AXIS_TVALID      (m_tvalid),
        .M_AXIS_TREADY      (m_tready),
        .FILT_OUT_TVALID    (filt_tvalid),
        .FILT_OUT_TREADY    (filt_tready),
        .COEFF_ADDR         (coeff_addr),
        .COEFF_DATA         (coeff_data),
        .COEFF_VALID        (coeff_valid),
        .LOAD_DONE          (load_done),
        .LOAD_ERROR         (load_error),
        .BUSY               (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {EV_WR, EV_DONE, EV_ERR} ev_kind_e;
    typedef struct {
        ev_kind_e      kind;
        int            addr;
        logic [DW-1:0] data;
        int            cyc;
    } ev_t;

    ev_t           sb[$];
    logic [DW-1:0] set_q [N_HALF];
    int            n_vec = 0;
    int            n_err = 0;
    bit            mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input ev_kind_e k, input int a, input logic [DW-1:0] d, input int c);
        ev_t e;
        e.kind = k; e.addr = a; e.data = d; e.cyc = c;
        sb.push_back(e);
    endtask

    // A full set is written in address order on consecutive cycles, then LOAD_DONE.
    task automatic push_writes(input int start, input int count);
        for (int i = 0; i < count; i++) push_ev(EV_WR, i, set_q[i], start + i);
        if (count == N_HALF) push_ev(EV_DONE, 0, '0, start + N_HALF);
    endtask

    task automatic expect_ev(input ev_kind_e k, input int a, input logic [DW-1:0] d);
        ev_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_event: got kind %0d addr %0d at cycle %0d, expected none",
                     int'(k), a, cyc);
        end else begin
            e = sb.pop_front();
            check("event_kind", 64'(int'(k)), 64'(int'(e.kind)));
            check("event_cycle", 64'(cyc), 64'(e.cyc));
            if (e.kind == EV_WR) begin
                check("coeff_addr", 64'(a), 64'(e.addr));
                check("coeff_data", 64'(d), 64'(e.data));
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (coeff_valid === 1'b1) expect_ev(EV_WR, int'(coeff_addr), coeff_data);
            if (load_done === 1'b1) expect_ev(EV_DONE, 0, '0);
            if (load_error === 1'b1) expect_ev(EV_ERR, 0, '0);
            if (busy === 1'b1) check("s_tready_while_busy", 64'(s_tready), 64'(0));
        end
    end

    task automatic send_beat(input logic [DW-1:0] d, input bit last, input bit gaps,
                             output int acc);
        int n;
        if (gaps && $urandom_range(0, 3) == 0) begin
            coeff_tvalid = 1'b0;
            @(posedge clk); #1;
        end
        coeff_tdata  = d;
        coeff_tvalid = 1'b1;
        coeff_tlast  = last;
        @(negedge clk);
        n = 0;
        while (coeff_tready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("coeff_tready_wait", 64'(coeff_tready), 64'(1));
        acc = cyc;
        @(posedge clk); #1;
        coeff_tvalid = 1'b0;
        coeff_tlast  = 1'b0;
    endtask

    // Reference model: exactly N_HALF beats loads the set, any other length is an error.
    task automatic send_set(input int len, input bit gaps, input bit use_base,
                            input int sample_beat, input bit auto_push, output int t_last);
        logic [DW-1:0] d;
        int acc;
        acc = 0;
        for (int k = 0; k < len; k++) begin
            d = use_base ? DW'(32'h1000 + k) : DW'($urandom);
            if (k < N_HALF) set_q[k] = d;
            if (k == sample_beat) begin
                s_tdata  = DW'($urandom);
                s_tvalid = 1'b1;
            end
            send_beat(d, k == len - 1, gaps, acc);
            s_tvalid = 1'b0;
        end
        t_last = acc;
        if (len != N_HALF) push_ev(EV_ERR, 0, '0, t_last + 1);
        else if (auto_push) push_writes(t_last + 2, N_HALF);
    endtask

    task automatic filt_hs(output int x);
        filt_tvalid = 1'b1;
        filt_tready = 1'b1;
        x = cyc;
        @(posedge clk); #1;
        filt_tvalid = 1'b0;
        filt_tready = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check("scoreboard_drained", 64'(sb.size()), 64'(0));
    endtask

    initial begin
        int t, x, len;
        rst = 1'b1;
        coeff_tdata = '0; coeff_tvalid = 1'b0; coeff_tlast = 1'b0;
        s_tdata = '0; s_tvalid = 1'b0; m_tready = 1'b1;
        filt_tvalid = 1'b0; filt_tready = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Reset state and sample pass-through
        s_tdata  = DW'($urandom);
        s_tvalid = 1'b1;
        @(negedge clk);
        check("rst_coeff_valid", 64'(coeff_valid), 64'(0));
        check("rst_coeff_addr", 64'(coeff_addr), 64'(0));
        check("rst_coeff_data", 64'(coeff_data), 64'(0));
        check("rst_load_done", 64'(load_done), 64'(0));
        check("rst_load_error", 64'(load_error), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_coeff_tready", 64'(coeff_tready), 64'(1));
        check("pass_m_tvalid", 64'(m_tvalid), 64'(1));
        check("pass_m_tdata", 64'(m_tdata), 64'(s_tdata));
        check("pass_s_tready", 64'(s_tready), 64'(1));
        m_tready = 1'b0;
        #1 check("pass_s_tready_low", 64'(s_tready), 64'(0));
        m_tready = 1'b1;
        s_tvalid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // Idle load with the 0x1000+k pattern
        send_set(N_HALF, 1'b0, 1'b1, -1, 1'b1, t);
        wait_drain();

        // Drain wait: sample accepted with beat N_HALF-2, result returns 40 cycles later
        send_set(N_HALF, 1'b0, 1'b0, N_HALF - 2, 1'b0, t);
        repeat (40) @(posedge clk); #1;
        check("drain_busy", 64'(busy), 64'(1));
        check("drain_s_tready", 64'(s_tready), 64'(0));
        check("drain_m_tvalid", 64'(m_tvalid), 64'(0));
        filt_hs(x);
        push_writes(x + 2, N_HALF);
        wait_drain();

        // Short set then a good set
        send_set(11, 1'b1, 1'b0, -1, 1'b1, t);
        send_set(N_HALF, 1'b1, 1'b0, -1, 1'b1, t);
        wait_drain();

        // Long set
        send_set(N_HALF + 8, 1'b1, 1'b0, -1, 1'b1, t);
        wait_drain();

        // Sample and result handshakes in the same cycle keep the sample in flight
        s_tdata = DW'($urandom); s_tvalid = 1'b1;
        @(posedge clk); #1;
        filt_tvalid = 1'b1; filt_tready = 1'b1;
        @(posedge clk); #1;
        s_tvalid = 1'b0; filt_tvalid = 1'b0; filt_tready = 1'b0;
        send_set(N_HALF, 1'b0, 1'b0, -1, 1'b0, t);
        repeat (10) @(posedge clk); #1;
        filt_hs(x);
        push_writes(x + 2, N_HALF);
        wait_drain();

        // Reset at write index 12, then a clean reload
        send_set(N_HALF, 1'b0, 1'b0, -1, 1'b0, t);
        push_writes(t + 2, 13);
        repeat (13) @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_coeff_valid", 64'(coeff_valid), 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_coeff_tready", 64'(coeff_tready), 64'(1));
        check("midrst_s_tready", 64'(s_tready), 64'(1));
        @(posedge clk); #1;
        send_set(N_HALF, 1'b1, 1'b0, -1, 1'b1, t);
        wait_drain();

        // Randomised set lengths, back to back
        for (int i = 0; i < 8; i++) begin
            case ($urandom_range(0, 2))
                0:       len = N_HALF;
                1:       len = $urandom_range(1, N_HALF - 1);
                default: len = $urandom_range(N_HALF + 1, N_HALF + 8);
            endcase
            send_set(len, 1'b1, 1'b0, -1, 1'b1, t);
        end
        wait_drain();

        repeat (5) @(posedge clk); #1;
        check("no_pending_events", 64'(sb.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axis_fir_coeff_loader.md
# axis_fir_coeff_loader

Run-time coefficient configurator for the sequential AXI-Stream FIR filter (`axis_fir_filter`). It receives a full half-set of symmetric coefficients on an AXI-Stream, holds them in a shadow buffer, and gates the filter's sample input until the current sample calculation has drained. It then replays the set onto the filter's `COEFF_ADDR`/`COEFF_DATA`/`COEFF_VALID` port. It sits between the upstream sample source and the filter input, with monitor taps on the filter output handshake.

## Interface
Parameters:
- `N_BYTES`, 4, sample/coefficient width in bytes; `DATA_WIDTH = N_BYTES*8`.
- `COEFF_ADDR_WIDTH`, 6, filter tap address width; `N_HALF = 2**(COEFF_ADDR_WIDTH-1)` coefficients per set.

Ports (clock and reset first):
- `CLK` in 1: single clock.
- `RESET` in 1: synchronous, active-high.
- `S_AXIS_COEFF_TDATA` in DATA_WIDTH: coefficient beat; beat k is coefficient k.
- `S_AXIS_COEFF_TVALID` in 1: coefficient beat valid.
- `S_AXIS_COEFF_TREADY` out 1: coefficient beat ready.
- `S_AXIS_COEFF_TLAST` in 1: last coefficient of the set.
- `S_AXIS_TDATA` in DATA_WIDTH: upstream sample data.
- `S_AXIS_TVALID` in 1: upstream sample valid.
- `S_AXIS_TREADY` out 1: upstream sample ready.
- `M_AXIS_TDATA` out DATA_WIDTH: sample data to the filter's `S_AXIS`.
- `M_AXIS_TVALID` out 1: sample valid to the filter.
- `M_AXIS_TREADY` in 1: filter sample ready.
- `FILT_OUT_TVALID` in 1: monitor tap on the filter `M_AXIS_TVALID`.
- `FILT_OUT_TREADY` in 1: monitor tap on the filter `M_AXIS_TREADY`.
- `COEFF_ADDR` out COEFF_ADDR_WIDTH: tap address to the filter; upper bit is always 0.
- `COEFF_DATA` out DATA_WIDTH: coefficient to the filter.
- `COEFF_VALID` out 1: coefficient write strobe.
- `LOAD_DONE` out 1: one-cycle pulse when a set is fully written.
- `LOAD_ERROR` out 1: one-cycle pulse when a set is rejected for length mismatch.
- `BUSY` out 1: high in DRAIN and WRITE.

## Operation
- **States:** RECEIVE, FLUSH, DRAIN, WRITE.
- **Gate.** `gate_open` is a register, high in RECEIVE and FLUSH. Sample path is combinational pass-through: `M_AXIS_TDATA = S_AXIS_TDATA`, `M_AXIS_TVALID = S_AXIS_TVALID & gate_open`, `S_AXIS_TREADY = M_AXIS_TREADY & gate_open`.
- **In-flight tracking.** `in_flight` sets on `M_AXIS_TVALID & M_AXIS_TREADY` and clears on `FILT_OUT_TVALID & FILT_OUT_TREADY`. If both occur in the same cycle, set wins.
- **RECEIVE.** `S_AXIS_COEFF_TREADY = 1`. Each accepted beat is written to `shadow[rx_cnt]` and `rx_cnt` increments.
  - TLAST on beat `N_HALF-1`: go to DRAIN.
  - TLAST on an earlier beat: pulse `LOAD_ERROR`, set `rx_cnt = 0`, stay in RECEIVE. The shadow contents are don't-care.
  - Beat `N_HALF-1` without TLAST: go to FLUSH.
- **FLUSH.** `S_AXIS_COEFF_TREADY = 1` and all beats are dropped. On TLAST: pulse `LOAD_ERROR`, set `rx_cnt = 0`, go to RECEIVE. The filter coefficients are untouched.
- **DRAIN.** `S_AXIS_COEFF_TREADY = 0` and the gate is closed. When `in_flight == 0`, go to WRITE.
- **WRITE.** For `N_HALF` consecutive cycles, `COEFF_VALID = 1` with `COEFF_ADDR = i` and `COEFF_DATA = shadow[i]`, for i = 0..N_HALF-1. After the last write: pulse `LOAD_DONE` and go to RECEIVE, which reopens the gate.
- A beat accepted in the same cycle the gate closes is counted in `in_flight`, and DRAIN waits for its result.
- **Reset.**
  - State becomes RECEIVE; `rx_cnt`, write index and `in_flight` become 0; `gate_open` becomes 1.
  - Reset values of outputs: `COEFF_VALID`, `COEFF_ADDR` and `COEFF_DATA` are 0. `LOAD_DONE`, `LOAD_ERROR` and `BUSY` are 0. `S_AXIS_COEFF_TREADY` is 1. The sample path is passed through.
- **Reset during WRITE** leaves the filter partially updated. This is the defined behaviour; the host must resend the set.

## Timing
- `COEFF_*`, `LOAD_DONE`, `LOAD_ERROR` and `BUSY` are registered outputs.
- Valid TLAST accepted at cycle T: state is DRAIN at T+1.
- If `in_flight = 0` at T+1:
  - `COEFF_VALID` is high for T+2 .. T+1+N_HALF.
  - `LOAD_DONE` is high at T+2+N_HALF.
  - Gate reopens at T+2+N_HALF.
- Otherwise WRITE starts the cycle after `in_flight` clears.
- `LOAD_ERROR` is high the cycle after the offending TLAST is accepted.
- Coefficient stream throughput: 1 beat/cycle in RECEIVE and FLUSH.

## Structure
- Shared package `axis_fir_pkg` holds the `loader_fsm` state enum and a `n_half(addr_width)` function.
  - `axis_fir_filter` uses the same function.
- Sub-module `fir_coeff_shadow_ram`: simple dual-port, `N_HALF x DATA_WIDTH`, registered read.
  - The read address is prefetched one cycle ahead so `COEFF_DATA` aligns with `COEFF_VALID`.
- The FSM, counters, `in_flight` and the gate live in the top module.

## Test plan
- **Idle load.** N_HALF=32, send 32 beats with values 0x1000+k, TLAST on beat 31, no samples in flight → `COEFF_VALID` high for 32 consecutive cycles starting T+2 with addr 0..31 and data 0x1000..0x101F; `LOAD_DONE` pulses at T+34.
- **Drain wait.** Sample accepted one cycle before the final TLAST; filter output handshake occurs 40 cycles later → no `COEFF_VALID` before that handshake; `S_AXIS_TREADY = 0` throughout DRAIN and WRITE.
- **Short set.** TLAST on beat 10 → `LOAD_ERROR` pulses once and `COEFF_VALID` never asserts; a following valid 32-beat set loads correctly.
- **Long set.** 40 beats, TLAST on beat 39 → beats 32..39 accepted and dropped, `LOAD_ERROR` pulses, no writes.
- **Reset mid-WRITE.** Assert `RESET` at write index 12 → next cycle `COEFF_VALID = 0`, `BUSY = 0`, `S_AXIS_COEFF_TREADY = 1`; a subsequent full set loads correctly.
- **Simultaneous handshakes.** Filter output and sample input handshakes in the same cycle → `in_flight` remains 1.
